clock_enable_gen: RTL and testbench
===================================

Name: clock_enable_gen

Overview:
- Multi-channel clock-enable generator driven from the single master clock.
- Each channel produces a one-cycle tick pulse every D master cycles, plus a mid-period pulse. These provide phi1/phi2-style enables for the CPU, PPU and other consumers.
- D is a per-channel divider, set by parameter and reloadable at runtime.
- Supports per-channel halt and a global resync that phase-aligns all channels.

Parameters:
- NUM_CHANNELS, 2, number of independent enable channels (>=1).
- COUNTER_WIDTH, 8, width of each divider counter and divider value.
- DEFAULT_DIVIDERS, {8'd4, 8'd12}, packed reset dividers. Channel i uses bits [i*COUNTER_WIDTH +: COUNTER_WIDTH]. Channel 0 = CPU (12), channel 1 = PPU (4). Every field must be nonzero.

Ports:
- clock_i  input  1  master clock; all logic on rising edge.
- reset_ni  input  1  synchronous, active-low reset.
- halt_i  input  NUM_CHANNELS  per-channel freeze; counter holds and no pulses are issued.
- resync_i  input  1  zeroes all counters and applies pending dividers.
- cfg_valid_i  input  1  divider write strobe.
- cfg_channel_i  input  $clog2(NUM_CHANNELS) (min 1)  target channel of the write.
- cfg_divider_i  input  COUNTER_WIDTH  new divider value D.
- cfg_error_o  output  1  one-cycle pulse when a write is rejected.
- tick_o  output  NUM_CHANNELS  registered period-end enable pulse per channel.
- mid_tick_o  output  NUM_CHANNELS  registered mid-period enable pulse per channel.

Behaviour:
- Reset (reset_ni=0 at a rising edge):
  - All counters = 0.
  - Active and shadow dividers = DEFAULT_DIVIDERS.
  - Pending flags = 0.
  - tick_o = 0, mid_tick_o = 0, cfg_error_o = 0.
  - Reset overrides every other input, including mid-operation.
- Counting: a running channel (halt_i[i]=0) increments its counter each cycle, range 0..D-1.
  - At counter == D-1 the counter wraps to 0 and tick_o[i] is registered high for exactly the following cycle.
  - D=12: first tick_o is high after the 12th rising edge following reset release, then every 12 cycles. Duty is 1/D.
- Mid pulse: on the edge where the counter advances from M-1 to M, with M = floor(D/2), mid_tick_o[i] is registered high for the following cycle.
  - D=1: mid_tick_o = tick_o, high every cycle.
  - D=2: mid_tick_o and tick_o alternate.
- Halt:
  - While halt_i[i]=1 the counter holds and tick_o[i]/mid_tick_o[i] stay 0.
  - Releasing halt resumes counting from the held value.
  - A pulse already registered when halt rises still completes its single cycle.
- Config write (cfg_valid_i=1):
  - If cfg_divider_i==0, or cfg_channel_i>=NUM_CHANNELS: the write is ignored and cfg_error_o pulses high the next cycle.
  - Otherwise the value goes to the channel shadow and the pending flag is set.
  - The active divider takes the shadow value on that channel's next wrap (counter D-1 -> 0). The current period always completes with the old D; no glitched period.
  - A second write before the wrap overwrites the shadow (last write wins).
  - A write in the same cycle as the wrap edge goes into the shadow and applies at the following wrap.
  - Writes are accepted while the channel is halted; they apply at the first wrap after release.
- Resync (resync_i=1):
  - Next edge: all counters = 0, all pending shadows become active, pending cleared. No tick_o or mid_tick_o is issued on that edge.
  - Counting resumes next cycle, so all channels then tick on common multiples.
  - Resync has priority over halt for the counter clear; halted channels stay halted.
  - Resync coincident with a valid cfg write: the written value is applied immediately.
- Arithmetic: compare against D-1 in COUNTER_WIDTH bits; no value outside 0..D-1 is reachable.
  - D = 2^COUNTER_WIDTH-1 is legal, for a maximum period of 255 at the default width.
- All outputs are registered; no combinational input-to-output paths.

Decomposition:
- Package clock_pkg:
  - CPU_DIVIDER = 12, PPU_DIVIDER = 4.
  - Channel index localparams CH_CPU = 0, CH_PPU = 1.
  - DEFAULT_DIVIDERS constant.
- Sub-module clock_divider_channel:
  - Contains one counter, active/shadow divider, pending flag, halt and resync handling, and the tick/mid registers.
  - Instantiated NUM_CHANNELS times by a generate loop.
- The top level handles cfg decode, range and zero checks, and cfg_error_o.

Test Plan:
- Reset release, defaults, no halt:
  - ch0 tick_o pulses on cycles 12, 24, 36.
  - ch1 pulses on cycles 4, 8, 12.
  - ch0 mid_tick_o on cycles 6, 18.
  - Both tick_o are coincident on cycle 12.
- Write ch0 D=5 at cycle 3: ticks at 12, 17, 22. The period in progress keeps D=12.
- Invalid writes:
  - Write D=0 to ch1: cfg_error_o high one cycle; ch1 period stays 4.
  - With NUM_CHANNELS=3, write to channel 3: same error response.
- halt_i[0] held for cycles 5-9: ch0 ticks at 17, 29. ch1 unaffected.
- Pending write of D=3 on ch1, then resync_i at cycle 7:
  - No pulses on the resync edge.
  - ch0 ticks 12 cycles later; ch1 ticks every 3 cycles from resync.
- Edge dividers:
  - D=1: tick_o continuously high.
  - D=2: alternating tick/mid.
  - D=255: period 255.
  - reset_ni asserted mid-period: all outputs 0 and counting restarts from cycle 0.

Source files
------------

// File: rtl/clock_pkg.sv
// -----------------------------------------------------------------------------
// clock_pkg
// Shared constants for the clock-enable generator: the CPU/PPU reset dividers,
// channel index names, the packed default divider word, and a helper that sizes
// the config channel-select field.
// -----------------------------------------------------------------------------
package clock_pkg;

    localparam int unsigned CPU_DIVIDER      = 12;
    localparam int unsigned PPU_DIVIDER      = 4;

    localparam int unsigned CH_CPU           = 0;
    localparam int unsigned CH_PPU           = 1;

    localparam int unsigned DEFAULT_WIDTH    = 8;
    localparam int unsigned DEFAULT_CHANNELS = 2;

    // Channel i occupies bits [i*DEFAULT_WIDTH +: DEFAULT_WIDTH].
    localparam logic [DEFAULT_CHANNELS*DEFAULT_WIDTH-1:0] DEFAULT_DIVIDERS =
        {DEFAULT_WIDTH'(PPU_DIVIDER), DEFAULT_WIDTH'(CPU_DIVIDER)};

    // Width of a channel index; a single channel still gets a 1-bit field.
    function automatic int unsigned chan_sel_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clock_enable_gen_if.sv
// -----------------------------------------------------------------------------
// clock_enable_gen_if
// Per-channel control/enable bundle between the generator top level and one
// divider channel.
//   wr_en      : accepted divider write for this channel
//   wr_divider : divider value carried with wr_en
//   halt       : freeze this channel
//   resync     : global phase-align request
//   tick       : registered period-end enable
//   mid_tick   : registered mid-period enable
// master = top-level control side, slave = divider channel.
// -----------------------------------------------------------------------------
interface clock_enable_gen_if #(
    parameter int unsigned COUNTER_WIDTH = 8
);

    logic                     wr_en;
    logic [COUNTER_WIDTH-1:0] wr_divider;
    logic                     halt;
    logic                     resync;
    logic                     tick;
    logic                     mid_tick;

    modport master (
        output wr_en,
        output wr_divider,
        output halt,
        output resync,
        input  tick,
        input  mid_tick
    );

    modport slave (
        input  wr_en,
        input  wr_divider,
        input  halt,
        input  resync,
        output tick,
        output mid_tick
    );

endinterface

// File: rtl/clock_divider_channel.sv
// -----------------------------------------------------------------------------
// clock_divider_channel
// One clock-enable channel: a 0..D-1 counter with active and shadow dividers.
// Emits a one-cycle tick on the wrap edge and a one-cycle mid pulse when the
// counter reaches floor(D/2). New dividers wait in the shadow until the next
// wrap (or a resync), so a period in progress always completes with its old D.
// Ports:
//   clock_i  : master clock (rising edge)
//   reset_ni : synchronous active-low reset
//   bus      : slave side of clock_enable_gen_if (write, halt, resync, pulses)
// -----------------------------------------------------------------------------
module clock_divider_channel
    import clock_pkg::*;
#(
    parameter int unsigned             COUNTER_WIDTH   = 8,
    parameter logic [COUNTER_WIDTH-1:0] DEFAULT_DIVIDER = COUNTER_WIDTH'(CPU_DIVIDER)
) (
    input  logic               clock_i,
    input  logic               reset_ni,
    clock_enable_gen_if.slave  bus
);

    localparam int unsigned CW = COUNTER_WIDTH;

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_div;
    logic [CW-1:0] r_shadow;
    logic          r_pending;
    logic          r_tick;
    logic          r_mid;

    logic          w_last;
    logic [CW-1:0] w_cnt_next;
    logic          w_mid_hit;

    // Active divider is never zero, so D-1 cannot underflow.
    assign w_last     = (r_cnt == r_div - CW'(1));
    assign w_cnt_next = w_last ? '0 : r_cnt + CW'(1);
    // For D=1 the midpoint is 0, so the mid pulse coincides with every tick.
    assign w_mid_hit  = (w_cnt_next == (r_div >> 1));

    assign bus.tick     = r_tick;
    assign bus.mid_tick = r_mid;

    // Counter, divider reload, and pulse registers.
    always_ff @(posedge clock_i) begin
        if (!reset_ni) begin
            r_cnt     <= '0;
            r_div     <= DEFAULT_DIVIDER;
            r_shadow  <= DEFAULT_DIVIDER;
            r_pending <= 1'b0;
            r_tick    <= 1'b0;
            r_mid     <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            r_mid  <= 1'b0;

            if (bus.wr_en) begin
                r_shadow  <= bus.wr_divider;
                r_pending <= 1'b1;
            end

            if (bus.resync) begin
                // Clear wins over halt; a same-cycle write takes effect at once.
                r_cnt <= '0;
                if (bus.wr_en) begin
                    r_div     <= bus.wr_divider;
                    r_pending <= 1'b0;
                end else if (r_pending) begin
                    r_div     <= r_shadow;
                    r_pending <= 1'b0;
                end
            end else if (!bus.halt) begin
                r_cnt  <= w_cnt_next;
                r_tick <= w_last;
                r_mid  <= w_mid_hit;
                // On a wrap the old shadow goes live; a write landing on the
                // same edge stays pending for the following wrap.
                if (w_last && r_pending) begin
                    r_div     <= r_shadow;
                    r_pending <= bus.wr_en;
                end
            end
        end
    end

endmodule

// File: rtl/clock_enable_gen.sv
// -----------------------------------------------------------------------------
// clock_enable_gen
// Multi-channel clock-enable generator. Decodes and validates divider writes,
// reports rejected writes, and fans halt/resync out to NUM_CHANNELS divider
// channels.
// Ports:
//   clock_i       : master clock (rising edge)
//   reset_ni      : synchronous active-low reset
//   halt_i        : per-channel freeze
//   resync_i      : zero all counters, apply pending dividers
//   cfg_valid_i   : divider write strobe
//   cfg_channel_i : write target channel
//   cfg_divider_i : new divider value
//   cfg_error_o   : registered one-cycle pulse for a rejected write
//   tick_o        : registered period-end enable per channel
//   mid_tick_o    : registered mid-period enable per channel
// -----------------------------------------------------------------------------
module clock_enable_gen #(
    parameter int unsigned NUM_CHANNELS  = 2,
    parameter int unsigned COUNTER_WIDTH = 8,
    parameter logic [NUM_CHANNELS*COUNTER_WIDTH-1:0] DEFAULT_DIVIDERS =
        clock_pkg::DEFAULT_DIVIDERS
) (
    input  logic                     clock_i,
    input  logic                     reset_ni,
    input  logic [NUM_CHANNELS-1:0]  halt_i,
    input  logic                     resync_i,
    input  logic                     cfg_valid_i,
    input  logic [clock_pkg::chan_sel_width(NUM_CHANNELS)-1:0] cfg_channel_i,
    input  logic [COUNTER_WIDTH-1:0] cfg_divider_i,
    output logic                     cfg_error_o,
    output logic [NUM_CHANNELS-1:0]  tick_o,
    output logic [NUM_CHANNELS-1:0]  mid_tick_o
);

    localparam int unsigned CW = COUNTER_WIDTH;

    logic                    w_ch_in_range;
    logic                    w_div_zero;
    logic                    w_accept;
    logic [NUM_CHANNELS-1:0] w_wr_en;
    logic                    r_cfg_error;

    // Channel-select width can exceed the channel count (e.g. 3 channels, 2 bits).
    assign w_ch_in_range = (32'(cfg_channel_i) < NUM_CHANNELS);
    assign w_div_zero    = (cfg_divider_i == '0);
    assign w_accept      = cfg_valid_i && w_ch_in_range && !w_div_zero;

    // One-hot write enable toward the addressed channel.
    always_comb begin
        w_wr_en = '0;
        for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
            if (w_accept && (32'(cfg_channel_i) == i)) begin
                w_wr_en[i] = 1'b1;
            end
        end
    end

    // Rejected-write flag, high for exactly the cycle after the strobe.
    always_ff @(posedge clock_i) begin
        if (!reset_ni) begin
            r_cfg_error <= 1'b0;
        end else begin
            r_cfg_error <= cfg_valid_i && !(w_ch_in_range && !w_div_zero);
        end
    end

    assign cfg_error_o = r_cfg_error;

    // One divider channel per enable output.
    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
        clock_enable_gen_if #(.COUNTER_WIDTH(CW)) u_bus ();

        assign u_bus.wr_en      = w_wr_en[g];
        assign u_bus.wr_divider = cfg_divider_i;
        assign u_bus.halt       = halt_i[g];
        assign u_bus.resync     = resync_i;

        clock_divider_channel #(
            .COUNTER_WIDTH   (CW),
            .DEFAULT_DIVIDER (DEFAULT_DIVIDERS[g*CW +: CW])
        ) u_channel (
            .clock_i  (clock_i),
            .reset_ni (reset_ni),
            .bus      (u_bus.slave)
        );

        assign tick_o[g]     = u_bus.tick;
        assign mid_tick_o[g] = u_bus.mid_tick;
    end

endmodule

// File: tb/tb_clock_enable_gen.sv
// -----------------------------------------------------------------------------
// tb_clock_enable_gen
// Self-checking bench for clock_enable_gen: directed scenarios with fixed
// expected tick cycles plus randomized traffic against a period-position model.
// -----------------------------------------------------------------------------
module tb_clock_enable_gen;

    logic       clk;
    logic       rst_n;
    logic [1:0] halt;
    logic       resync;
    logic       cfg_valid;
    logic [0:0] cfg_ch;
    logic [7:0] cfg_div;
    logic       cfg_err;
    logic [1:0] tick;
    logic [1:0] mid;

    logic       cfg3_valid;
    logic [1:0] cfg3_ch;
    logic [7:0] cfg3_div;
    logic       cfg3_err;
    logic [2:0] tick3;
    logic [2:0] mid3;

    int n_checks = 0;
    int n_fail   = 0;

    clock_enable_gen dut (
        .clock_i       (clk),
        .reset_ni      (rst_n),
        .halt_i        (halt),
        .resync_i      (resync),
        .cfg_valid_i   (cfg_valid),
        .cfg_channel_i (cfg_ch),
        .cfg_divider_i (cfg_div),
        .cfg_error_o   (cfg_err),
        .tick_o        (tick),
        .mid_tick_o    (mid)
    );

    clock_enable_gen #(
        .NUM_CHANNELS     (3),
        .COUNTER_WIDTH    (8),
        .DEFAULT_DIVIDERS ({8'd6, 8'd4, 8'd12})
    ) dut3 (
        .clock_i       (clk),
        .reset_ni      (rst_n),
        .halt_i        (3'b000),
        .resync_i      (1'b0),
        .cfg_valid_i   (cfg3_valid),
        .cfg_channel_i (cfg3_ch),
        .cfg_divider_i (cfg3_div),
        .cfg_error_o   (cfg3_err),
        .tick_o        (tick3),
        .mid_tick_o    (mid3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model (2-channel DUT) ----------------
    // Tracks how many running cycles of the current period have elapsed.
    int         m_pos [2];
    int         m_d   [2];
    int         m_sh  [2];
    bit         m_pend[2];
    logic [1:0] exp_tick;
    logic [1:0] exp_mid;
    logic       exp_err;

    always @(posedge clk) begin
        bit wr_ok;
        if (!rst_n) begin
            m_d[0] = clock_pkg::CPU_DIVIDER;
            m_d[1] = clock_pkg::PPU_DIVIDER;
            for (int i = 0; i < 2; i++) begin
                m_pos[i]  = 0;
                m_sh[i]   = m_d[i];
                m_pend[i] = 0;
            end
            exp_tick = '0;
            exp_mid  = '0;
            exp_err  = 1'b0;
        end else begin
            wr_ok   = cfg_valid && (cfg_div != 0) && (int'(cfg_ch) < 2);
            exp_err = cfg_valid && !wr_ok;
            for (int i = 0; i < 2; i++) begin
                bit t, m, wr;
                t  = 0;
                m  = 0;
                wr = wr_ok && (int'(cfg_ch) == i);
                if (resync) begin
                    m_pos[i] = 0;
                    if (wr) begin
                        m_d[i] = int'(cfg_div); m_pend[i] = 0;
                    end else if (m_pend[i]) begin
                        m_d[i] = m_sh[i]; m_pend[i] = 0;
                    end
                end else if (!halt[i]) begin
                    m_pos[i] = m_pos[i] + 1;
                    m = ((m_pos[i] % m_d[i]) == (m_d[i] / 2));
                    if (m_pos[i] == m_d[i]) begin
                        t = 1;
                        m_pos[i] = 0;
                        if (m_pend[i]) begin
                            m_d[i] = m_sh[i]; m_pend[i] = 0;
                        end
                    end
                end
                if (wr && !resync) begin
                    m_sh[i] = int'(cfg_div); m_pend[i] = 1;
                end
                exp_tick[i] = t;
                exp_mid[i]  = m;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        halt = '0; resync = 0; cfg_valid = 0; cfg_ch = '0; cfg_div = '0;
        cfg3_valid = 0; cfg3_ch = '0; cfg3_div = '0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 0;
        step();
        step();
        rst_n = 1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 0;
        halt = 2'b11; resync = 1; cfg_valid = 1; cfg_ch = 1'b1; cfg_div = 8'd0;
        for (int k = 0; k < 3; k++) begin
            step();
            n_checks++;
            if ({tick, mid, cfg_err} !== 5'b0) begin
                n_fail++;
                $display("FAIL reset_outputs k=%0d got tick=%b mid=%b err=%b want all 0", k, tick, mid, cfg_err);
            end
        end
        idle();
        step();
        n_checks++;
        if ({tick, mid, cfg_err} !== {exp_tick, exp_mid, exp_err}) begin
            n_fail++;
            $display("FAIL reset_model got %b%b%b want %b%b%b", tick, mid, cfg_err, exp_tick, exp_mid, exp_err);
        end
        rst_n = 1;
    endtask

    task automatic test_defaults();
        int t0[$]; int t1[$]; int m0[$]; int both[$];
        for (int c = 1; c <= 40; c++) begin
            step();
            if (tick[0]) t0.push_back(c);
            if (tick[1]) t1.push_back(c);
            if (mid[0])  m0.push_back(c);
            if (tick == 2'b11) both.push_back(c);
            n_checks++;
            if ({tick, mid, cfg_err} !== {exp_tick, exp_mid, exp_err}) begin
                n_fail++;
                $display("FAIL defaults_model c=%0d got %b %b %b want %b %b %b", c, tick, mid, cfg_err, exp_tick, exp_mid, exp_err);
            end
        end
        n_checks++;
        if (t0.size() != 3 || t0[0] != 12 || t0[1] != 24 || t0[2] != 36) begin
            n_fail++;
            $display("FAIL defaults_ch0_ticks got n=%0d %0d,%0d,%0d want 12,24,36", t0.size(), t0[0], t0[1], t0[2]);
        end
        n_checks++;
        if (t1.size() != 10 || t1[0] != 4 || t1[1] != 8 || t1[2] != 12) begin
            n_fail++;
            $display("FAIL defaults_ch1_ticks got n=%0d %0d,%0d,%0d want n=10 4,8,12", t1.size(), t1[0], t1[1], t1[2]);
        end
        n_checks++;
        if (m0.size() != 3 || m0[0] != 6 || m0[1] != 18 || m0[2] != 30) begin
            n_fail++;
            $display("FAIL defaults_ch0_mid got n=%0d %0d,%0d want 6,18,30", m0.size(), m0[0], m0[1]);
        end
        n_checks++;
        if (both.size() == 0 || both[0] != 12) begin
            n_fail++;
            $display("FAIL defaults_coincident got n=%0d first=%0d want first=12", both.size(), both.size() ? both[0] : -1);
        end
    endtask

    task automatic test_reload();
        int t0[$];
        do_reset();
        for (int c = 1; c <= 30; c++) begin
            if (c == 3) begin cfg_valid = 1; cfg_ch = 1'b0; cfg_div = 8'd5; end
            step();
            cfg_valid = 0;
            if (tick[0]) t0.push_back(c);
            n_checks++;
            if ({tick, mid, cfg_err} !== {exp_tick, exp_mid, exp_err}) begin
                n_fail++;
                $display("FAIL reload_model c=%0d got %b %b %b want %b %b %b", c, tick, mid, cfg_err, exp_tick, exp_mid, exp_err);
            end
        end
        n_checks++;
        if (t0.size() < 3 || t0[0] != 12 || t0[1] != 17 || t0[2] != 22) begin
            n_fail++;
            $display("FAIL reload_ch0_ticks got %0d,%0d,%0d want 12,17,22", t0[0], t0[1], t0[2]);
        end
    endtask

    task automatic test_invalid();
        int t1[$];
        do_reset();
        step();
        cfg_valid = 1; cfg_ch = 1'b1; cfg_div = 8'd0;
        cfg3_valid = 1; cfg3_ch = 2'd3; cfg3_div = 8'd7;
        step();
        idle();
        n_checks++;
        if (cfg_err !== 1'b1 || cfg3_err !== 1'b1) begin
            n_fail++;
            $display("FAIL invalid_err_pulse got err=%b err3=%b want 1 1", cfg_err, cfg3_err);
        end
        cfg3_valid = 1; cfg3_ch = 2'd2; cfg3_div = 8'd7;
        step();
        idle();
        n_checks++;
        if (cfg_err !== 1'b0 || cfg3_err !== 1'b0) begin
            n_fail++;
            $display("FAIL invalid_err_width got err=%b err3=%b want 0 0", cfg_err, cfg3_err);
        end
        for (int c = 4; c <= 20; c++) begin
            step();
            if (tick[1]) t1.push_back(c);
            n_checks++;
            if ({tick, mid, cfg_err} !== {exp_tick, exp_mid, exp_err}) begin
                n_fail++;
                $display("FAIL invalid_model c=%0d got %b %b %b want %b %b %b", c, tick, mid, cfg_err, exp_tick, exp_mid, exp_err);
            end
        end
        n_checks++;
        if (t1.size() != 5 || t1[0] != 4 || t1[1] != 8 || t1[4] != 20) begin
            n_fail++;
            $display("FAIL invalid_ch1_period got n=%0d %0d,%0d want 4,8,12,16,20", t1.size(), t1[0], t1[1]);
        end
    endtask

    task automatic test_halt();
        int t0[$]; int t1[$];
        do_reset();
        for (int c = 1; c <= 35; c++) begin
            halt[0] = (c >= 5 && c <= 9);
            step();
            if (tick[0]) t0.push_back(c);
            if (tick[1]) t1.push_back(c);
            n_checks++;
            if ({tick, mid, cfg_err} !== {exp_tick, exp_mid, exp_err}) begin
                n_fail++;
                $display("FAIL halt_model c=%0d got %b %b %b want %b %b %b", c, tick, mid, cfg_err, exp_tick, exp_mid, exp_err);
            end
        end
        halt = '0;
        n_checks++;
        if (t0.size() != 2 || t0[0] != 17 || t0[1] != 29) begin
            n_fail++;
            $display("FAIL halt_ch0_ticks got n=%0d %0d,%0d want 17,29", t0.size(), t0[0], t0[1]);
        end
        n_checks++;
        if (t1.size() < 3 || t1[0] != 4 || t1[1] != 8 || t1[2] != 12) begin
            n_fail++;
            $display("FAIL halt_ch1_ticks got %0d,%0d,%0d want 4,8,12", t1[0], t1[1], t1[2]);
        end
    endtask

    task automatic test_resync();
        int t0[$]; int t1[$];
        do_reset();
        for (int c = 1; c <= 30; c++) begin
            cfg_valid = (c == 5); cfg_ch = 1'b1; cfg_div = 8'd3;
            resync    = (c == 7);
            step();
            if (c == 7) begin
                n_checks++;
                if (tick !== 2'b00 || mid !== 2'b00) begin
                    n_fail++;
                    $display("FAIL resync_no_pulse got tick=%b mid=%b want 00 00", tick, mid);
                end
            end
            if (c > 7 && tick[0]) t0.push_back(c);
            if (c > 7 && tick[1]) t1.push_back(c);
            n_checks++;
            if ({tick, mid, cfg_err} !== {exp_tick, exp_mid, exp_err}) begin
                n_fail++;
                $display("FAIL resync_model c=%0d got %b %b %b want %b %b %b", c, tick, mid, cfg_err, exp_tick, exp_mid, exp_err);
            end
        end
        idle();
        n_checks++;
        if (t0.size() == 0 || t0[0] != 19) begin
            n_fail++;
            $display("FAIL resync_ch0_tick got n=%0d first=%0d want 19", t0.size(), t0.size() ? t0[0] : -1);
        end
        n_checks++;
        if (t1.size() < 3 || t1[0] != 10 || t1[1] != 13 || t1[2] != 16) begin
            n_fail++;
            $display("FAIL resync_ch1_ticks got %0d,%0d,%0d want 10,13,16", t1[0], t1[1], t1[2]);
        end
    endtask

    task automatic test_edge_dividers();
        int t0[$];
        do_reset();
        // D=1 applied immediately by a coincident resync.
        cfg_valid = 1; cfg_ch = 1'b1; cfg_div = 8'd1; resync = 1;
        step();
        idle();
        for (int k = 1; k <= 10; k++) begin
            step();
            n_checks++;
            if (tick[1] !== 1'b1 || mid[1] !== 1'b1) begin
                n_fail++;
                $display("FAIL div1_continuous k=%0d got tick=%b mid=%b want 1 1", k, tick[1], mid[1]);
            end
        end
        cfg_valid = 1; cfg_ch = 1'b1; cfg_div = 8'd2; resync = 1;
        step();
        idle();
        for (int k = 1; k <= 10; k++) begin
            step();
            n_checks++;
            if (tick[1] !== ((k % 2) == 0) || mid[1] !== ((k % 2) == 1)) begin
                n_fail++;
                $display("FAIL div2_alternate k=%0d got tick=%b mid=%b want %0d %0d", k, tick[1], mid[1], (k % 2) == 0, (k % 2) == 1);
            end
        end
        cfg_valid = 1; cfg_ch = 1'b0; cfg_div = 8'd255; resync = 1;
        step();
        idle();
        for (int k = 1; k <= 520; k++) begin
            step();
            if (tick[0]) t0.push_back(k);
            n_checks++;
            if ({tick, mid, cfg_err} !== {exp_tick, exp_mid, exp_err}) begin
                n_fail++;
                $display("FAIL div255_model k=%0d got %b %b %b want %b %b %b", k, tick, mid, cfg_err, exp_tick, exp_mid, exp_err);
            end
        end
        n_checks++;
        if (t0.size() != 2 || t0[0] != 255 || t0[1] != 510) begin
            n_fail++;
            $display("FAIL div255_period got n=%0d %0d,%0d want 255,510", t0.size(), t0[0], t0[1]);
        end
    endtask

    task automatic test_reset_mid();
        int t0[$]; int t1[$];
        do_reset();
        for (int c = 1; c <= 7; c++) step();
        rst_n = 0; cfg_valid = 1; cfg_ch = 1'b0; cfg_div = 8'd3;
        step();
        idle();
        n_checks++;
        if ({tick, mid, cfg_err} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs got tick=%b mid=%b err=%b want all 0", tick, mid, cfg_err);
        end
        rst_n = 1;
        for (int c = 1; c <= 14; c++) begin
            step();
            if (tick[0]) t0.push_back(c);
            if (tick[1]) t1.push_back(c);
        end
        n_checks++;
        if (t0.size() != 1 || t0[0] != 12 || t1.size() < 1 || t1[0] != 4) begin
            n_fail++;
            $display("FAIL reset_mid_restart got ch0 n=%0d first=%0d ch1 first=%0d want 12 and 4", t0.size(), t0[0], t1[0]);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 1; c <= 800; c++) begin
            if ($urandom_range(0, 15) == 0) halt[$urandom_range(0, 1)] ^= 1'b1;
            resync    = ($urandom_range(0, 39) == 0);
            cfg_valid = ($urandom_range(0, 5) == 0);
            cfg_ch    = 1'($urandom_range(0, 1));
            cfg_div   = 8'($urandom_range(0, 9));
            step();
            n_checks++;
            if ({tick, mid, cfg_err} !== {exp_tick, exp_mid, exp_err}) begin
                n_fail++;
                $display("FAIL random_model c=%0d got %b %b %b want %b %b %b", c, tick, mid, cfg_err, exp_tick, exp_mid, exp_err);
            end
        end
        idle();
    endtask

    initial begin
        idle();
        rst_n = 0;
        test_reset();
        test_defaults();
        test_reload();
        test_invalid();
        test_halt();
        test_resync();
        test_edge_dividers();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
